// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the floating-point execute units:
// field widths, canonical NaN, fflags bit positions, divider FSM states
// and the operand classifier (also used by the multiplier).
package fp_pkg;

  localparam int          EXP_W     = 8;
  localparam int          FRAC_W    = 23;
  localparam int          BIAS      = 127;
  localparam int          QUOT_BITS = 26;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // fflags bit positions inside {NV,DZ,OF,UF,NX}
  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } fdiv_state_e;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_class_t;

  // Classify exponent/fraction bits of an FP32 value. Subnormals count as
  // zero because the FP units flush them to zero on input.
  function automatic fp_class_t fp_classify(input logic [30:0] x);
    fp_class_t c;
    logic      exp_zero;
    logic      exp_max;
    logic      frac_zero;
    exp_zero  = (x[30:23] == 8'h00);
    exp_max   = (x[30:23] == 8'hFF);
    frac_zero = (x[22:0] == 23'h0);
    c.is_zero = exp_zero;
    c.is_inf  = exp_max & frac_zero;
    c.is_nan  = exp_max & ~frac_zero;
    c.is_snan = exp_max & ~frac_zero & ~x[22];
    return c;
  endfunction

endpackage

// File: rtl/mantissa_divider.sv
// Radix-2 restoring divider for normalized 24-bit mantissas. One quotient
// bit per cycle, QUOT_BITS cycles after start_i. done_o is high during the
// final iteration so the caller can leave its wait state on that same edge;
// quot_o/sticky_o are final from the following cycle and then held.
module mantissa_divider
  import fp_pkg::*;
#(
  parameter int QUOT_BITS_P = QUOT_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [23:0]            dividend_i,
  input  logic [23:0]            divisor_i,
  output logic [QUOT_BITS_P-1:0] quot_o,
  output logic                   sticky_o,
  output logic                   done_o
);

  localparam int CNT_W = $clog2(QUOT_BITS_P);

  logic [24:0]            rem_q;
  logic [23:0]            div_q;
  logic [QUOT_BITS_P-1:0] quot_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   run_q;

  logic [25:0] diff_d;
  logic        ge_d;
  logic [24:0] rem_d;
  logic        last_d;

  // Trial subtraction: keep the difference only when it is non-negative.
  always_comb begin
    diff_d = {1'b0, rem_q} - {2'b00, div_q};
    ge_d   = ~diff_d[25];
    if (ge_d) begin
      rem_d = diff_d[24:0];
    end else begin
      rem_d = rem_q;
    end
    last_d = run_q && (cnt_q == CNT_W'(QUOT_BITS_P - 1));
  end

  // Load on start, then shift in one quotient bit per cycle until the last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= 25'h0;
      div_q  <= 24'h0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      rem_q  <= {1'b0, dividend_i};
      div_q  <= divisor_i;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      quot_q <= {quot_q[QUOT_BITS_P-2:0], ge_d};
      rem_q  <= rem_d << 1;
      if (last_d) begin
        cnt_q <= '0;
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign quot_o   = quot_q;
  assign sticky_o = |rem_q;
  assign done_o   = last_d;

endmodule

// File: rtl/float_division_unit.sv
// Iterative FP32 divider (fdiv.s): unpack and special-case detection,
// restoring mantissa division, RNE rounding with flush-to-zero, and a
// busy/valid handshake. Result and fflags are held until the next accept.
module float_division_unit
  import fp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] operand1_i,
  input  logic [31:0] operand2_i,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o,
  output logic        busy_o,
  output logic        valid_o
);

  fdiv_state_e       state_q;
  logic [31:0]       op1_q;
  logic [31:0]       op2_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [31:0]       result_q;
  logic [4:0]        flags_q;
  logic              busy_q;
  logic              valid_q;

  fp_class_t         cls1_d;
  fp_class_t         cls2_d;
  logic              sign_d;
  logic signed [9:0] exp_d;
  logic              special_d;
  logic [31:0]       spec_result_d;
  logic [4:0]        spec_flags_d;

  logic [QUOT_BITS-1:0] quot_s;
  logic                 rem_sticky_s;
  logic                 div_done_s;
  logic                 div_start_s;

  logic              norm_d;
  logic [22:0]       frac_d;
  logic              guard_d;
  logic              sticky_d;
  logic              round_up_d;
  logic [23:0]       frac_sum_d;
  logic signed [9:0] exp_r_d;
  logic [31:0]       round_result_d;
  logic [4:0]        round_flags_d;

  // Unpack: sign, biased exponent difference and special-case result.
  always_comb begin
    cls1_d        = fp_classify(op1_q[30:0]);
    cls2_d        = fp_classify(op2_q[30:0]);
    sign_d        = op1_q[31] ^ op2_q[31];
    exp_d         = $signed({2'b00, op1_q[30:23]}) - $signed({2'b00, op2_q[30:23]})
                    + 10'sd127;
    special_d     = 1'b1;
    spec_result_d = 32'h0;
    spec_flags_d  = 5'b00000;
    if (cls1_d.is_nan || cls2_d.is_nan) begin
      spec_result_d    = CANON_NAN;
      spec_flags_d[NV] = cls1_d.is_snan | cls2_d.is_snan;
    end else if ((cls1_d.is_zero && cls2_d.is_zero) || (cls1_d.is_inf && cls2_d.is_inf)) begin
      spec_result_d    = CANON_NAN;
      spec_flags_d[NV] = 1'b1;
    end else if (cls2_d.is_zero) begin
      spec_result_d    = {sign_d, 8'hFF, 23'h0};
      spec_flags_d[DZ] = 1'b1;
    end else if (cls1_d.is_inf) begin
      spec_result_d    = {sign_d, 8'hFF, 23'h0};
    end else if (cls2_d.is_inf || cls1_d.is_zero) begin
      spec_result_d    = {sign_d, 31'h0};
    end else begin
      special_d        = 1'b0;
    end
  end

  assign div_start_s = (state_q == S_UNPACK) && !special_d;

  mantissa_divider #(
    .QUOT_BITS_P (QUOT_BITS)
  ) u_mant_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start_s),
    .dividend_i ({1'b1, op1_q[22:0]}),
    .divisor_i  ({1'b1, op2_q[22:0]}),
    .quot_o     (quot_s),
    .sticky_o   (rem_sticky_s),
    .done_o     (div_done_s)
  );

  // Normalize, round to nearest even, then resolve overflow/underflow.
  always_comb begin
    norm_d = quot_s[QUOT_BITS-1];
    if (norm_d) begin
      frac_d   = quot_s[QUOT_BITS-2:2];
      guard_d  = quot_s[1];
      sticky_d = quot_s[0] | rem_sticky_s;
      exp_r_d  = exp_q;
    end else begin
      frac_d   = quot_s[QUOT_BITS-3:1];
      guard_d  = quot_s[0];
      sticky_d = rem_sticky_s;
      exp_r_d  = exp_q - 10'sd1;
    end
    round_up_d = guard_d & (sticky_d | frac_d[0]);
    frac_sum_d = {1'b0, frac_d} + {23'h0, round_up_d};
    // Fraction overflow means the mantissa rounded up to 2.0.
    exp_r_d    = exp_r_d + $signed({9'h0, frac_sum_d[23]});
    round_flags_d = 5'b00000;
    if (exp_r_d >= 10'sd255) begin
      round_result_d    = {sign_q, 8'hFF, 23'h0};
      round_flags_d[OF] = 1'b1;
      round_flags_d[NX] = 1'b1;
    end else if (exp_r_d <= 10'sd0) begin
      round_result_d    = {sign_q, 31'h0};
      round_flags_d[UF] = 1'b1;
      round_flags_d[NX] = 1'b1;
    end else begin
      round_result_d    = {sign_q, exp_r_d[7:0], frac_sum_d[22:0]};
      round_flags_d[NX] = guard_d | sticky_d;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      result_q <= 32'h0;
      flags_q  <= 5'b00000;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            op1_q   <= operand1_i;
            op2_q   <= operand2_i;
            busy_q  <= 1'b1;
            state_q <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= sign_d;
          exp_q  <= exp_d;
          if (special_d) begin
            result_q <= spec_result_d;
            flags_q  <= spec_flags_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (div_done_s) begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          result_q <= round_result_d;
          flags_q  <= round_flags_d;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign busy_o   = busy_q;
  assign valid_o  = valid_q;

endmodule
